chdr_fifo_integrity_checker: RTL and testbench
==============================================

Name: chdr_fifo_integrity_checker

Overview:
- Zero-latency AXI-Stream monitor on the CHDR (CVITA) path directly downstream of the DRAM-backed DMA FIFO output (o_tdata/o_tlast of the dual DRAM FIFO).
- Passes traffic through untouched.
- Parses each packet header and checks the length field against the actual beat count and tlast.
- Checks 12-bit sequence-number continuity and exposes saturating error/packet counters for readback by the DMA FIFO block's user registers.

Parameters:
- CNT_W, 32, width of pkt_count.
- ERR_W, 16, width of seq_err_count and len_err_count.
- SEQ_CHECK_EN, 1, 0 disables sequence checking; seq_err_count stays 0.

Ports:
- clk  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of counters, flags and sequence history
- i_tdata  in  64  CHDR stream from FIFO
- i_tlast  in  1  end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  64  CHDR stream to consumer
- o_tlast  out  1  end of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- pkt_count  out  CNT_W  packets completed (tlast beats), saturating
- seq_err_count  out  ERR_W  sequence discontinuities, saturating
- len_err_count  out  ERR_W  length/tlast mismatches, saturating
- last_seqnum  out  12  seqnum of most recent header
- err_sticky  out  2  [0]=seq error seen, [1]=length error seen; cleared only by reset/clear
- err_pulse  out  1  one-cycle pulse, registered, on any new error

Behaviour:
- Data path is combinational pass-through:
  - o_tdata=i_tdata, o_tlast=i_tlast, o_tvalid=i_tvalid, i_tready=o_tready.
  - Zero latency; the block never stalls or modifies data.
- beat = i_tvalid & o_tready. All monitoring advances only on beat.
- Header fields on the first line:
  - seqnum=[59:48], length=[47:32] in bytes including header.
  - exp_lines = (length+7)>>3, 13-bit.
- FSM states HEAD, BODY, DRAIN; reset state HEAD.
- HEAD, on beat:
  - Latch last_seqnum and exp_lines; line_cnt=1.
  - If length<8: length error. Go HEAD if tlast, else DRAIN.
  - Else if tlast and exp_lines==1: good packet, stay HEAD.
  - Else if tlast and exp_lines>1: length error (early tlast), stay HEAD.
  - Else if exp_lines==1 and no tlast: length error, DRAIN.
  - Else BODY.
- BODY, on beat:
  - line_cnt++.
  - If tlast and line_cnt+1==exp_lines: good, HEAD.
  - If tlast and line_cnt+1<exp_lines: length error, HEAD.
  - If no tlast and line_cnt+1==exp_lines: length error, DRAIN.
- DRAIN: ignore beats until a tlast beat, then HEAD. No further errors are counted for that packet; at most one length error per packet.
- pkt_count increments on every tlast beat, in every state.
- Sequence check, when SEQ_CHECK_EN:
  - A "seen" flag is cleared by reset/clear.
  - On each HEAD beat with seen=1, seqnum != prev+1 (mod 4096) gives a seq error.
  - prev is then updated to the received seqnum, so errors do not cascade. seen is set on every HEAD beat.
  - Wrap 4095->0 is legal.
- Counters saturate at all-ones; no wrap.
- A seq error and a length error on the same beat both count; err_pulse=1 once.
- clear:
  - Zeroes counters, err_sticky, seen and last_seqnum.
  - A beat in the same cycle is not counted.
  - FSM goes to HEAD if idle or if the concurrent beat has tlast; otherwise DRAIN, to resync at the next tlast.
- reset, asynchronous: all registered outputs 0, FSM HEAD, seen=0. Pass-through outputs follow inputs.

Decomposition:
- Shared package chdr_check_pkg:
  - Header bit-position constants (SEQ_HI/LO, LEN_HI/LO).
  - State enum.
  - Function chdr_len_to_lines(length) returning 13-bit exp_lines.
- One natural sub-module: sat_counter (WIDTH param, inc, clear), instantiated for each of the three counters.

Test Plan:
- Four good packets:
  - Stimulus: seq 0..3, length 24 (3 lines), tlast on line 3, o_tready=1.
  - Required: pkt_count=4, both error counts 0, last_seqnum=3, err_sticky=0.
- Seq gap:
  - Stimulus: packets with seq 10, 11, 13, 14.
  - Required: seq_err_count=1, err_sticky[0]=1, one err_pulse; wrap test 4095->0 gives no error.
- Early tlast:
  - Stimulus: length 32 with tlast on line 2.
  - Required: len_err_count=1, next packet (seq+1, length 16) checks good; pkt_count=2.
- Late tlast:
  - Stimulus: length 16 with tlast on line 5.
  - Required: len_err_count=1 (not 3), FSM in DRAIN for lines 3-5, next packet good.
- Backpressure:
  - Stimulus: random o_tready (~50%) over 100 packets of length 1040 (130 lines), contiguous seqnums.
  - Required: o_* bit-identical to i_*, zero errors, pkt_count=100.
- clear and reset mid-packet:
  - Stimulus: assert clear on line 2 of a 4-line packet.
  - Required: counters 0, that packet not counted as error, pkt_count=1 after its tlast.
  - Stimulus: async reset mid-packet.
  - Required: outputs 0 immediately, first post-reset packet with any seqnum gives no seq error.

Source files
------------

// File: rtl/chdr_check_pkg.sv
// Shared definitions for the CHDR FIFO integrity checker: header field
// positions, parser state encoding and the byte-length to line-count helper.
package chdr_check_pkg;

    localparam int SEQ_HI = 59;
    localparam int SEQ_LO = 48;
    localparam int LEN_HI = 47;
    localparam int LEN_LO = 32;

    typedef enum logic [1:0] {
        ST_HEAD  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } chk_state_t;

    // Length counts bytes including the header line; round up to 64-bit lines.
    // Lengths above 65528 do not fit in 13 bits and wrap to 0 lines.
    function automatic logic [12:0] chdr_len_to_lines(input logic [15:0] length);
        logic [16:0] w_sum;
        w_sum = {1'b0, length} + 17'd7;
        return w_sum[15:3];
    endfunction

endpackage

// File: rtl/chdr_fifo_integrity_checker_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/chdr_fifo_integrity_checker.sv
// Zero-latency CHDR stream monitor: passes data through and checks header
// length against beat count/tlast plus sequence-number continuity.
module chdr_fifo_integrity_checker
    import chdr_check_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int ERR_W        = 16,
    parameter bit SEQ_CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [63:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [63:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CNT_W-1:0] pkt_count,
    output logic [ERR_W-1:0] seq_err_count,
    output logic [ERR_W-1:0] len_err_count,
    output logic [11:0]      last_seqnum,
    output logic [1:0]       err_sticky,
    output logic             err_pulse
);

    chk_state_t  r_state;
    chk_state_t  w_state_nxt;
    logic [12:0] r_exp_lines;
    logic [12:0] r_line_cnt;
    logic [11:0] r_last_seqnum;
    logic        r_seen;
    logic [1:0]  r_err_sticky;
    logic        r_err_pulse;

    logic        w_beat;
    logic [11:0] w_seq;
    logic [15:0] w_len;
    logic [12:0] w_exp;
    logic [12:0] w_line_nxt;
    logic [11:0] w_seq_exp;
    logic        w_len_err;
    logic        w_seq_err;
    logic        w_pkt_inc;
    logic        w_seq_inc;
    logic        w_len_inc;

    assign o_tdata  = i_tdata;
    assign o_tlast  = i_tlast;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;

    assign w_beat     = i_tvalid & o_tready;
    assign w_seq      = i_tdata[SEQ_HI:SEQ_LO];
    assign w_len      = i_tdata[LEN_HI:LEN_LO];
    assign w_exp      = chdr_len_to_lines(w_len);
    assign w_line_nxt = r_line_cnt + 13'd1;
    assign w_seq_exp  = r_last_seqnum + 12'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_len_err   = 1'b0;
        if (w_beat) begin
            case (r_state)
                ST_HEAD: begin
                    if (w_len < 16'd8) begin
                        w_len_err   = 1'b1;
                        w_state_nxt = i_tlast ? ST_HEAD : ST_DRAIN;
                    end else if (i_tlast) begin
                        w_len_err   = (w_exp != 13'd1);
                        w_state_nxt = ST_HEAD;
                    end else if (w_exp == 13'd1) begin
                        w_len_err   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (i_tlast) begin
                        w_len_err   = (w_line_nxt != r_exp_lines);
                        w_state_nxt = ST_HEAD;
                    end else if (w_line_nxt == r_exp_lines) begin
                        w_len_err   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_tlast) w_state_nxt = ST_HEAD;
                end
                default: w_state_nxt = ST_HEAD;
            endcase
        end
    end

    // The first header after reset/clear only seeds the history.
    assign w_seq_err = SEQ_CHECK_EN && w_beat && (r_state == ST_HEAD) &&
                       r_seen && (w_seq != w_seq_exp);

    assign w_pkt_inc = w_beat & i_tlast & ~clear;
    assign w_seq_inc = w_seq_err & ~clear;
    assign w_len_inc = w_len_err & ~clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HEAD;
        end else if (clear) begin
            // Resync: a packet cut by clear is skipped up to its tlast.
            if (w_beat)
                r_state <= i_tlast ? ST_HEAD : ST_DRAIN;
            else
                r_state <= (r_state == ST_HEAD) ? ST_HEAD : ST_DRAIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_lines <= '0;
            r_line_cnt  <= '0;
        end else if (w_beat) begin
            if (r_state == ST_HEAD) begin
                r_exp_lines <= w_exp;
                r_line_cnt  <= 13'd1;
            end else if (r_state == ST_BODY) begin
                r_line_cnt  <= w_line_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_seqnum <= '0;
            r_seen        <= 1'b0;
        end else if (clear) begin
            r_last_seqnum <= '0;
            r_seen        <= 1'b0;
        end else if (w_beat && (r_state == ST_HEAD)) begin
            r_last_seqnum <= w_seq;
            r_seen        <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_sticky <= '0;
            r_err_pulse  <= 1'b0;
        end else if (clear) begin
            r_err_sticky <= '0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_err_sticky <= r_err_sticky | {w_len_err, w_seq_err};
            r_err_pulse  <= w_len_err | w_seq_err;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_pkt_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .i_inc   (w_pkt_inc),
        .o_count (pkt_count)
    );

    sat_counter #(.WIDTH(ERR_W)) u_seq_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .i_inc   (w_seq_inc),
        .o_count (seq_err_count)
    );

    sat_counter #(.WIDTH(ERR_W)) u_len_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .i_inc   (w_len_inc),
        .o_count (len_err_count)
    );

    assign last_seqnum = r_last_seqnum;
    assign err_sticky  = r_err_sticky;
    assign err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_chdr_fifo_integrity_checker.sv
// Directed bench for the CHDR integrity checker with immediate-assertion checks.
module tb_chdr_fifo_integrity_checker;
    import chdr_check_pkg::*;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] pkt_count;
    logic [15:0] seq_err_count;
    logic [15:0] len_err_count;
    logic [11:0] last_seqnum;
    logic [1:0]  err_sticky;
    logic        err_pulse;

    int checks;
    int failures;
    int pulse_cnt;
    int p0;
    int bp_bad;

    chdr_fifo_integrity_checker #(.CNT_W(32), .ERR_W(16), .SEQ_CHECK_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .i_tdata       (i_tdata),
        .i_tlast       (i_tlast),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .pkt_count     (pkt_count),
        .seq_err_count (seq_err_count),
        .len_err_count (len_err_count),
        .last_seqnum   (last_seqnum),
        .err_sticky    (err_sticky),
        .err_pulse     (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulse_cnt = 0;
    always @(negedge clk) if (err_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [11:0] s, input logic [15:0] l);
        return {4'h0, s, l, 32'hA5A5_0000};
    endfunction

    task automatic beat(input logic [63:0] d, input logic l);
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        o_tready = 1'b1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic pkt(input logic [11:0] s, input logic [15:0] l, input int n);
        for (int k = 0; k < n; k++)
            beat((k == 0) ? hdr(s, l) : {32'hB0D1_0000, k[31:0]}, (k == n - 1));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Holds each line until accepted under random o_tready, checking pass-through every cycle.
    task automatic bp_pkt(input logic [11:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            i_tdata  = (k == 0) ? hdr(s, 16'(n * 8)) : {s, 20'h0, k[31:0]};
            i_tlast  = (k == n - 1);
            i_tvalid = 1'b1;
            for (int w = 0; w < 200; w++) begin
                o_tready = 1'($urandom_range(0, 1));
                #1;
                if (o_tdata !== i_tdata || o_tlast !== i_tlast ||
                    o_tvalid !== i_tvalid || i_tready !== o_tready)
                    bp_bad++;
                @(posedge clk);
                #1;
                if (o_tready) break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; bp_bad = 0;
        reset = 1'b1; clear = 1'b0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_seqerr", 64'(seq_err_count), 64'd0);
        chk("rst_lenerr", 64'(len_err_count), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_pulse", 64'(err_pulse), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // four good 3-line packets
        for (int s = 0; s < 4; s++) pkt(12'(s), 16'd24, 3);
        chk("good_pkt", 64'(pkt_count), 64'd4);
        chk("good_seqerr", 64'(seq_err_count), 64'd0);
        chk("good_lenerr", 64'(len_err_count), 64'd0);
        chk("good_lastseq", 64'(last_seqnum), 64'd3);
        chk("good_sticky", 64'(err_sticky), 64'd0);

        // sequence gap 11 -> 13
        do_clear();
        chk("clr_pkt", 64'(pkt_count), 64'd0);
        p0 = pulse_cnt;
        pkt(12'd10, 16'd24, 3);
        pkt(12'd11, 16'd24, 3);
        pkt(12'd13, 16'd24, 3);
        pkt(12'd14, 16'd24, 3);
        repeat (2) @(posedge clk); #1;
        chk("gap_seqerr", 64'(seq_err_count), 64'd1);
        chk("gap_sticky", 64'(err_sticky), 64'd1);
        chk("gap_pulses", 64'(pulse_cnt - p0), 64'd1);
        chk("gap_pkt", 64'(pkt_count), 64'd4);
        chk("gap_lastseq", 64'(last_seqnum), 64'd14);

        // wrap 4095 -> 0 is continuous
        do_clear();
        pkt(12'd4095, 16'd16, 2);
        pkt(12'd0, 16'd16, 2);
        chk("wrap_seqerr", 64'(seq_err_count), 64'd0);
        chk("wrap_pkt", 64'(pkt_count), 64'd2);

        // early tlast: length 32 (4 lines) ends on line 2
        do_clear();
        p0 = pulse_cnt;
        pkt(12'd5, 16'd32, 2);
        pkt(12'd6, 16'd16, 2);
        repeat (2) @(posedge clk); #1;
        chk("early_lenerr", 64'(len_err_count), 64'd1);
        chk("early_pkt", 64'(pkt_count), 64'd2);
        chk("early_seqerr", 64'(seq_err_count), 64'd0);
        chk("early_sticky", 64'(err_sticky), 64'd2);
        chk("early_pulses", 64'(pulse_cnt - p0), 64'd1);

        // late tlast: length 16 (2 lines) ends on line 5
        do_clear();
        beat(hdr(12'd20, 16'd16), 1'b0);
        beat(64'd1, 1'b0);
        chk("late_drain_l3", 64'(dut.r_state), 64'(ST_DRAIN));
        beat(64'd2, 1'b0);
        beat(64'd3, 1'b0);
        chk("late_drain_l5", 64'(dut.r_state), 64'(ST_DRAIN));
        beat(64'd4, 1'b1);
        chk("late_head", 64'(dut.r_state), 64'(ST_HEAD));
        pkt(12'd21, 16'd16, 2);
        chk("late_lenerr", 64'(len_err_count), 64'd1);
        chk("late_pkt", 64'(pkt_count), 64'd2);
        chk("late_seqerr", 64'(seq_err_count), 64'd0);

        // backpressure: 100 packets of 130 lines
        do_clear();
        for (int s = 0; s < 100; s++) bp_pkt(12'(s), 130);
        o_tready = 1'b1;
        chk("bp_passthru", 64'(bp_bad), 64'd0);
        chk("bp_pkt", 64'(pkt_count), 64'd100);
        chk("bp_seqerr", 64'(seq_err_count), 64'd0);
        chk("bp_lenerr", 64'(len_err_count), 64'd0);
        chk("bp_lastseq", 64'(last_seqnum), 64'd99);

        // clear on line 2 of a 4-line packet
        beat(hdr(12'd50, 16'd32), 1'b0);
        clear = 1'b1;
        beat(64'd1, 1'b0);
        clear = 1'b0;
        chk("mclr_pkt0", 64'(pkt_count), 64'd0);
        chk("mclr_lastseq", 64'(last_seqnum), 64'd0);
        beat(64'd2, 1'b0);
        beat(64'd3, 1'b1);
        chk("mclr_pkt1", 64'(pkt_count), 64'd1);
        chk("mclr_lenerr", 64'(len_err_count), 64'd0);
        chk("mclr_sticky", 64'(err_sticky), 64'd0);
        pkt(12'd7, 16'd16, 2);
        chk("mclr_seqerr", 64'(seq_err_count), 64'd0);
        chk("mclr_pkt2", 64'(pkt_count), 64'd2);

        // async reset mid-packet
        pkt(12'd101, 16'd32, 2);
        beat(hdr(12'd102, 16'd24), 1'b0);
        i_tdata = 64'hDEAD_BEEF_0123_4567;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pkt", 64'(pkt_count), 64'd0);
        chk("arst_lenerr", 64'(len_err_count), 64'd0);
        chk("arst_sticky", 64'(err_sticky), 64'd0);
        chk("arst_lastseq", 64'(last_seqnum), 64'd0);
        chk("arst_passthru", o_tdata, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pkt(12'd3000, 16'd16, 2);
        pkt(12'd3001, 16'd16, 2);
        chk("post_seqerr", 64'(seq_err_count), 64'd0);
        chk("post_lenerr", 64'(len_err_count), 64'd0);
        chk("post_pkt", 64'(pkt_count), 64'd2);
        chk("post_lastseq", 64'(last_seqnum), 64'd3001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
